pll_div_bank: RTL and testbench

PLL_DIV_BANK -- requirements
Module: pll_div_bank

---
 rtl/pll_div_bank_pkg.sv | 19 +
 rtl/pll_div_chan.sv | 119 +++++++++++
 rtl/pll_div_bank.sv | 91 +++++++++
 tb/tb_pll_div_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_div_bank_pkg.sv
// pll_div_bank_pkg: shared types and default constants for the divided-clock bank.
//   chan_state_e  per-channel lock state machine encoding
//   DEF_*         default values for the pll_div_bank / pll_div_chan parameters
package pll_div_bank_pkg;

  typedef enum logic [1:0] {
    CH_LOCKED  = 2'd0,
    CH_PENDING = 2'd1,
    CH_RELOCK  = 2'd2
  } chan_state_e;

  localparam int unsigned DEF_NUM_CHANNELS = 3;
  localparam int unsigned DEF_DIV_WIDTH    = 8;
  localparam int unsigned DEF_LOCK_CYCLES  = 16;
  localparam int unsigned DEF_RESET_DIV    = 1;
  localparam int unsigned DEF_RT_DIV       = 4;
  localparam int unsigned LOSS_CNT_W       = 8;

endpackage

// File: rtl/pll_div_chan.sv
// pll_div_chan: one divided-clock channel with glitch-free divider switching.
//   clk_i, rst_i    reference clock, synchronous active-high reset
//   wr, wr_div      accepted config write for this channel and its new half-period
//   pending         channel holds a not-yet-applied divide value
//   clk_o           registered divided clock (low while div = 0)
//   lock_o          channel is LOCKED
//   lock_loss_cnt   saturating LOCKED->PENDING count (PLL_DIV_BANK_LOCKCNT_EN only)
module pll_div_chan
  import pll_div_bank_pkg::*;
#(
  parameter int unsigned DivWidth   = DEF_DIV_WIDTH,
  parameter int unsigned LockCycles = DEF_LOCK_CYCLES,
  parameter int unsigned ResetDiv   = DEF_RESET_DIV
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr,
  input  logic [DivWidth-1:0] wr_div,
  output logic                pending,
  output logic                clk_o,
  output logic                lock_o
`ifdef PLL_DIV_BANK_LOCKCNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam int unsigned LcW = (LockCycles > 1) ? $clog2(LockCycles) : 1;

  chan_state_e         state, state_n;
  logic [DivWidth-1:0] div, div_n, pend, pend_n, cnt, cnt_n;
  logic [LcW-1:0]      lcnt, lcnt_n;
  logic                clk_q, clk_n, tick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= CH_RELOCK;
      div   <= DivWidth'(ResetDiv);
      pend  <= '0;
      cnt   <= '0;
      lcnt  <= '0;
      clk_q <= 1'b0;
    end else begin
      state <= state_n;
      div   <= div_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
      lcnt  <= lcnt_n;
      clk_q <= clk_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    pend_n  = pend;
    cnt_n   = cnt;
    lcnt_n  = lcnt;
    clk_n   = clk_q;
    tick    = (div != '0) && (cnt == div - 1'b1);

    // Free-running half-period divider at the current div.
    if (div == '0) begin
      cnt_n = '0;
      clk_n = 1'b0;
    end else if (tick) begin
      cnt_n = '0;
      clk_n = ~clk_q;
    end else begin
      cnt_n = cnt + 1'b1;
    end

    unique case (state)
      CH_LOCKED: begin
        if (wr) begin
          pend_n  = wr_div;
          state_n = CH_PENDING;
        end
      end
      CH_RELOCK: begin
        if (wr) begin
          pend_n  = wr_div;
          state_n = CH_PENDING;
        end else if (lcnt == LcW'(LockCycles - 1)) begin
          state_n = CH_LOCKED;
        end else begin
          lcnt_n = lcnt + 1'b1;
        end
      end
      CH_PENDING: begin
        // Switch only when the output is low and about to rise, so the
        // old high phase always completes and the new one starts from zero.
        if ((div == '0) || (tick && !clk_q)) begin
          div_n   = pend;
          cnt_n   = '0;
          clk_n   = 1'b0;
          lcnt_n  = '0;
          state_n = CH_RELOCK;
        end
      end
      default: state_n = CH_RELOCK;
    endcase
  end

  assign pending = (state == CH_PENDING);
  assign lock_o  = (state == CH_LOCKED);
  assign clk_o   = clk_q;

`ifdef PLL_DIV_BANK_LOCKCNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_loss_cnt <= '0;
    end else if ((state == CH_LOCKED) && wr && (lock_loss_cnt != '1)) begin
      lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/pll_div_bank.sv
// pll_div_bank: bank of NumChannels reconfigurable divided clocks plus a fixed rt clock.
//   clk_i, rst_i          sole reference clock, synchronous active-high reset
//   cfg_valid_i/ready_o   config handshake; ready low only while addressed channel is pending
//   cfg_ch_i, cfg_div_i   target channel and new half-period (0 gates the channel)
//   cfg_err_o             one-cycle pulse after an accepted out-of-range channel
//   clk_o, lock_o         per-channel divided clock and lock indication
//   rt_clk_o              fixed clock, half-period RtDiv
//   lock_loss_cnt_o       per-channel 8-bit lock-loss counts, only with PLL_DIV_BANK_LOCKCNT_EN
module pll_div_bank
  import pll_div_bank_pkg::*;
#(
  parameter int unsigned NumChannels = DEF_NUM_CHANNELS,
  parameter int unsigned DivWidth    = DEF_DIV_WIDTH,
  parameter int unsigned LockCycles  = DEF_LOCK_CYCLES,
  parameter int unsigned ResetDiv    = DEF_RESET_DIV,
  parameter int unsigned RtDiv       = DEF_RT_DIV,
  localparam int unsigned ChW        = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [ChW-1:0]         cfg_ch_i,
  input  logic [DivWidth-1:0]    cfg_div_i,
  output logic                   cfg_err_o,
  output logic [NumChannels-1:0] clk_o,
  output logic [NumChannels-1:0] lock_o,
  output logic                   rt_clk_o
`ifdef PLL_DIV_BANK_LOCKCNT_EN
  ,
  output logic [NumChannels*LOSS_CNT_W-1:0] lock_loss_cnt_o
`endif
);

  localparam int unsigned RtW = (RtDiv > 1) ? $clog2(RtDiv) : 1;

  logic [NumChannels-1:0] pending, wr;
  logic                   hit;
  logic [RtW-1:0]         rt_cnt;

  // Address decode by comparison keeps out-of-range channels from indexing.
  always_comb begin
    hit         = 1'b0;
    cfg_ready_o = 1'b1;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      if (cfg_ch_i == ChW'(i)) begin
        hit = 1'b1;
        if (pending[i]) cfg_ready_o = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    assign wr[g] = cfg_valid_i && cfg_ready_o && (cfg_ch_i == ChW'(g));

    pll_div_chan #(
      .DivWidth  (DivWidth),
      .LockCycles(LockCycles),
      .ResetDiv  (ResetDiv)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr     (wr[g]),
      .wr_div (cfg_div_i),
      .pending(pending[g]),
      .clk_o  (clk_o[g]),
      .lock_o (lock_o[g])
`ifdef PLL_DIV_BANK_LOCKCNT_EN
      ,
      .lock_loss_cnt(lock_loss_cnt_o[g*LOSS_CNT_W +: LOSS_CNT_W])
`endif
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_err_o <= 1'b0;
      rt_cnt    <= '0;
      rt_clk_o  <= 1'b0;
    end else begin
      cfg_err_o <= cfg_valid_i && !hit;
      if (rt_cnt == RtW'(RtDiv - 1)) begin
        rt_cnt   <= '0;
        rt_clk_o <= ~rt_clk_o;
      end else begin
        rt_cnt <= rt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_div_bank.sv
// tb_pll_div_bank: directed bench for pll_div_bank with a cycle-level reference model.
module tb_pll_div_bank;

  localparam int NCH = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int RESET_DIV = 1;
  localparam int RT_DIV = 4;
  localparam int ST_LOCKED = 0, ST_PEND = 1, ST_RELOCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] ch = '0;
  logic [7:0] dv = '0;
  logic       cfg_ready_o, cfg_err_o, rt_clk_o;
  logic [2:0] clk_o, lock_o;
`ifdef PLL_DIV_BANK_LOCKCNT_EN
  logic [23:0] lock_loss_cnt_o;
`endif

  pll_div_bank #(
    .NumChannels(NCH),
    .DivWidth   (8),
    .LockCycles (LOCK_CYCLES),
    .ResetDiv   (RESET_DIV),
    .RtDiv      (RT_DIV)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_valid_i(valid),
    .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i   (ch),
    .cfg_div_i  (dv),
    .cfg_err_o  (cfg_err_o),
    .clk_o      (clk_o),
    .lock_o     (lock_o),
    .rt_clk_o   (rt_clk_o)
`ifdef PLL_DIV_BANK_LOCKCNT_EN
    ,
    .lock_loss_cnt_o(lock_loss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: each channel's output is derived from cycles elapsed
  // since its divider was (re)started, not from a counter/toggle register.
  int m_div[NCH], m_pend[NCH], m_st[NCH], m_t[NCH], m_rl[NCH], m_ll[NCH];
  int m_rt;
  bit m_err;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = RESET_DIV; m_st[i] = ST_RELOCK; m_t[i] = 0; m_rl[i] = 0; m_ll[i] = 0;
      end
      m_err = 1'b0;
      m_rt  = 0;
    end else begin
      m_err = valid && (ch >= NCH);
      m_rt++;
      for (int i = 0; i < NCH; i++) begin
        if (m_st[i] == ST_PEND) begin
          if (m_div[i] == 0 ||
              (((m_t[i] / m_div[i]) % 2 == 0) && (((m_t[i] + 1) / m_div[i]) % 2 == 1))) begin
            m_div[i] = m_pend[i]; m_st[i] = ST_RELOCK; m_t[i] = 0; m_rl[i] = 0;
          end else begin
            m_t[i]++;
          end
        end else begin
          m_t[i]++;
          if (valid && ch == i) begin
            if (m_st[i] == ST_LOCKED && m_ll[i] < 255) m_ll[i]++;
            m_pend[i] = dv;
            m_st[i]   = ST_PEND;
          end else if (m_st[i] == ST_RELOCK) begin
            m_rl[i]++;
            if (m_rl[i] == LOCK_CYCLES) m_st[i] = ST_LOCKED;
          end
        end
      end
    end
  end

  logic [2:0] e_clk, e_lock;
  logic       e_rdy;

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NCH; i++) begin
        e_clk[i]  = (m_div[i] == 0) ? 1'b0 : 1'(((m_t[i] / m_div[i]) % 2));
        e_lock[i] = (m_st[i] == ST_LOCKED);
      end
      e_rdy = (ch < NCH) ? (m_st[ch] != ST_PEND) : 1'b1;
      chk("clk_o", 32'(clk_o), 32'(e_clk));
      chk("lock_o", 32'(lock_o), 32'(e_lock));
      chk("cfg_ready_o", 32'(cfg_ready_o), 32'(e_rdy));
      chk("cfg_err_o", 32'(cfg_err_o), 32'(m_err));
      chk("rt_clk_o", 32'(rt_clk_o), 32'((m_rt / RT_DIV) % 2));
`ifdef PLL_DIV_BANK_LOCKCNT_EN
      for (int i = 0; i < NCH; i++)
        chk("lock_loss_cnt", 32'(lock_loss_cnt_o[i*8 +: 8]), 32'(m_ll[i]));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [7:0] d);
    int n = 0;
    valid = 1'b1; ch = c; dv = d;
    while (!cfg_ready_o && n < 50) begin step(); n++; end
    chk("cfg_accept_timeout", 32'(cfg_ready_o), 32'd1);
    step();
    valid = 1'b0;
  endtask

  task automatic run_len(input int idx, input logic lvl, output int n);
    n = 0;
    while (clk_o[idx] == lvl && n < 40) begin step(); n++; end
  endtask

  task automatic wait_lock(input int idx);
    int n = 0;
    while (!lock_o[idx] && n < 60) begin step(); n++; end
    chk("lock_timeout", 32'(lock_o[idx]), 32'd1);
  endtask

  task automatic reset_relock_checks(input string tag);
    repeat (15) step();
    chk({tag, "_lock_low"}, 32'(lock_o), 32'd0);
    step();
    chk({tag, "_lock_high"}, 32'(lock_o), 32'h7);
    chk({tag, "_clk_even"}, 32'(clk_o), 32'h0);
    step();
    chk({tag, "_clk_odd"}, 32'(clk_o), 32'h7);
  endtask

  initial begin
    int hi, lo, n;
    bit saw_high;
    step();
    step();
    check_en = 1'b1;
    rst = 1'b0;
    chk("rst_ready", 32'(cfg_ready_o), 32'd1);
    chk("rst_clk", 32'(clk_o), 32'd0);
    reset_relock_checks("por");

    // ch1 -> div 3: 3 high / 3 low after the switch, relock afterwards.
    cfg_write(2'd1, 8'd3);
    chk("ch1_lock_drop", 32'(lock_o[1]), 32'd0);
    repeat (4) step();
    run_len(1, 1'b1, n);
    run_len(1, 1'b0, n);
    run_len(1, 1'b1, hi);
    run_len(1, 1'b0, lo);
    chk("ch1_high_len", 32'(hi), 32'd3);
    chk("ch1_low_len", 32'(lo), 32'd3);
    wait_lock(1);

    // ch2 -> div 0: gated low, still relocks.
    cfg_write(2'd2, 8'd0);
    repeat (3) step();
    saw_high = 1'b0;
    repeat (8) begin
      if (clk_o[2]) saw_high = 1'b1;
      step();
    end
    chk("ch2_gated", 32'(saw_high), 32'd0);
    wait_lock(2);

    // Out-of-range channel: error pulse only.
    cfg_write(2'd3, 8'd5);
    chk("err_pulse", 32'(cfg_err_o), 32'd1);
    chk("err_no_change", 32'(lock_o), 32'h7);
    step();
    chk("err_clear", 32'(cfg_err_o), 32'd0);

    // ch0 div 8 then a second request held until ready returns.
    valid = 1'b1; ch = 2'd0; dv = 8'd8;
    step();
    dv = 8'd2;
    chk("ready_low_pending", 32'(cfg_ready_o), 32'd0);
    chk("ch0_lock_drop", 32'(lock_o[0]), 32'd0);
    n = 0;
    while (!cfg_ready_o && n < 50) begin step(); n++; end
    chk("ready_returns", 32'(cfg_ready_o), 32'd1);
    step();
    valid = 1'b0;
    chk("second_accepted", 32'(cfg_ready_o), 32'd0);
    wait_lock(0);

    // Reset in the middle of RELOCK after div 5.
    cfg_write(2'd1, 8'd5);
    repeat (10) step();
    chk("ch1_mid_relock", 32'(lock_o[1]), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_lock", 32'(lock_o), 32'd0);
    chk("midrst_clk", 32'(clk_o), 32'd0);
    chk("midrst_rt", 32'(rt_clk_o), 32'd0);
    reset_relock_checks("midrst");
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
